// File: rtl/mem_rd_arbiter.sv
// Two-requester read arbiter for a single registered-read memory port.
// Round-robin grant, read-after-write hazard stall, one read in flight.
module mem_rd_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [DATA_W-1:0] r_data_i,
    input  logic              w_en_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_q;
    logic              id_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] r_addr_q;

    logic              win_id;
    logic [ADDR_W-1:0] win_addr;
    logic              hazard;
    logic              grant;

    // Winner is chosen first; the hazard then only vetoes that winner,
    // so a stalled winner never hands the slot to the other requester.
    always_comb begin
        win_id = 1'b0;
        if (req0_i && req1_i) begin
            win_id = ~last_q;
        end else begin
            win_id = req1_i;
        end
        win_addr = win_id ? addr1_i : addr0_i;
        hazard   = w_en_i && (w_addr_i == win_addr);
        grant    = (state_q == IDLE) && (req0_i || req1_i) && !hazard && !reset;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
            r_addr_q  <= '0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        r_addr_q <= win_addr;
                        id_q     <= win_id;
                        last_q   <= win_id;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    rdata_q   <= r_data_i;
                    rvalid0_q <= ~id_q;
                    rvalid1_q <= id_q;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0_o    = grant & ~win_id;
    assign gnt1_o    = grant & win_id;
    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata_o   = rdata_q;
    assign r_addr_o  = r_addr_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have port clk_in  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req0_i  input  1  read request, requester 0 (serial readback path).
REQ-006 SHALL have port addr0_i  input  ADDR_W  read address, requester 0.
REQ-007 SHALL have port gnt0_o  output  1  one-cycle pulse: requester 0 address accepted.
REQ-008 SHALL have port rvalid0_o  output  1  one-cycle pulse: rdata_o holds requester 0 result.
REQ-009 SHALL have port req1_i  input  1  read request, requester 1 (PID engine).
REQ-010 SHALL have port addr1_i  input  ADDR_W  read address, requester 1.
REQ-011 SHALL have port gnt1_o  output  1  one-cycle pulse: requester 1 address accepted.
REQ-012 SHALL have port rvalid1_o  output  1  one-cycle pulse: rdata_o holds requester 1 result.
REQ-013 SHALL have port rdata_o  output  DATA_W  registered read data, shared by both requesters.
REQ-014 SHALL have port r_addr_o  output  ADDR_W  read address to memory read port.
REQ-015 SHALL have port r_data_i  input  DATA_W  memory read data; valid one cycle after r_addr_o is presented (registered read).
REQ-016 SHALL have port w_en_i  input  1  memory write strobe, monitored only.
REQ-017 SHALL have port w_addr_i  input  ADDR_W  memory write address, monitored only.
REQ-018 SHALL have port busy_o  output  1  high in every state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT; exactly one read in flight at any time.
REQ-020 IDLE: if any req_i high and no hazard (REQ-024), SHALL select winner, latch its address and ID, pulse its gnt, go to ISSUE; otherwise stay in IDLE.
REQ-021 ISSUE: SHALL drive r_addr_o with latched address; go to WAIT unconditionally.
REQ-022 WAIT: SHALL hold r_addr_o, capture r_data_i into rdata_o at end of cycle, set the latched ID's rvalid for the following cycle, go to IDLE.
REQ-023 Arbitration SHALL be round-robin: single requester wins outright; both requesting -> the one not granted last wins; last-grant register updates only on a grant.
REQ-024 Read-after-write hazard: if winner's address equals w_addr_i while w_en_i high in IDLE, SHALL withhold grant that cycle; last-grant register unchanged; re-evaluate next cycle.
REQ-025 Hazard SHALL be checked on the selected winner only; losing requester is not promoted in the same cycle.
REQ-026 Requester SHALL hold req and addr until its gnt; addr sampled only on the grant cycle; addr changes afterwards SHALL be ignored.
REQ-027 Latency: gnt in cycle N -> r_addr_o valid in N+1 -> rvalid high and rdata_o valid in N+3.
REQ-028 A new grant SHALL be allowed in the same cycle rvalid is high (IDLE re-entered); peak throughput one read per 3 cycles.
REQ-029 rdata_o SHALL hold its value until the next WAIT capture; rvalid0_o and rvalid1_o never high together; gnt0_o and gnt1_o never high together.
REQ-030 r_addr_o SHALL hold its last value in IDLE.
REQ-031 req dropped after gnt SHALL not cancel the read; rvalid still issued.

Reset
REQ-032 reset high SHALL force IDLE immediately, regardless of clock.
REQ-033 Reset values: gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, busy_o = 0; rdata_o = 0; r_addr_o = 0; last-grant = requester 1 (requester 0 wins first contest).
REQ-034 Reset during ISSUE or WAIT SHALL abort the read; no rvalid pulse after reset release.
REQ-035 First grant possible on the first rising edge with reset low.

Verification
REQ-036 Single read: memory[0x10]=0xBEEF, req0 addr 0x10 in IDLE -> gnt0 at N, r_addr_o=0x10 at N+1, rvalid0 and rdata_o=0xBEEF at N+3.
REQ-037 Contention: req0 and req1 high from reset release, addr 0x01/0x02 -> grant order 0,1,0,1; rvalid data matches memory each time; gnts 3 cycles apart.
REQ-038 Hazard: w_en_i=1, w_addr_i=0x20 for 2 cycles, req1 addr 0x20 -> no gnt1 during those 2 cycles, gnt1 on first cycle w_en_i low, rdata_o returns newly written value.
REQ-039 Reset mid-read: assert reset during WAIT of a req0 read -> all outputs 0 at once, no rvalid0 after release; next contest grants requester 0.
REQ-040 Address change after grant: gnt1 for addr 0x05, addr1_i changed to 0x06 next cycle -> r_addr_o=0x05, rdata_o=memory[0x05].
REQ-041 Back-to-back: req0 held continuously with req1 low -> gnt0 at N, N+3, N+6; rvalid0 coincides with each following gnt0.
